// File: rtl/comm_defs_pkg.sv
// Shared definitions for the UART command path: execution states, response
// kinds, ASCII constants and the response byte-vector builder.
package comm_defs_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUS_REQ,
    BUS_RD,
    RESP
  } exec_state_e;

  typedef enum logic [1:0] {
    RSP_DERR,
    RSP_WOK,
    RSP_ROK,
    RSP_TOUT
  } resp_kind_e;

  // Byte 0 is the first byte on the wire.
  typedef logic [6:0][7:0] resp_bytes_t;

  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_9  = 8'h39;
  localparam logic [7:0] ASCII_E  = 8'h45;
  localparam logic [7:0] ASCII_K  = 8'h4B;

  localparam logic [2:0] LEN_DERR = 3'd5;
  localparam logic [2:0] LEN_WOK  = 3'd3;
  localparam logic [2:0] LEN_ROK  = 3'd7;
  localparam logic [2:0] LEN_TOUT = 3'd5;

  function automatic resp_bytes_t build_resp(input resp_kind_e kind,
                                             input logic [15:0] code,
                                             input logic [31:0] rdata);
    resp_bytes_t b;
    b = '0;
    case (kind)
      RSP_DERR: begin
        b[0] = ASCII_E;
        b[1] = code[15:8];
        b[2] = code[7:0];
        b[3] = ASCII_CR;
        b[4] = ASCII_LF;
      end
      RSP_WOK: begin
        b[0] = ASCII_K;
        b[1] = ASCII_CR;
        b[2] = ASCII_LF;
      end
      RSP_ROK: begin
        b[0] = ASCII_K;
        b[1] = rdata[31:24];
        b[2] = rdata[23:16];
        b[3] = rdata[15:8];
        b[4] = rdata[7:0];
        b[5] = ASCII_CR;
        b[6] = ASCII_LF;
      end
      default: begin
        b[0] = ASCII_E;
        b[1] = ASCII_9;
        b[2] = ASCII_9;
        b[3] = ASCII_CR;
        b[4] = ASCII_LF;
      end
    endcase
    return b;
  endfunction

  function automatic logic [2:0] resp_len(input resp_kind_e kind);
    logic [2:0] len;
    case (kind)
      RSP_DERR: len = LEN_DERR;
      RSP_WOK:  len = LEN_WOK;
      RSP_ROK:  len = LEN_ROK;
      default:  len = LEN_TOUT;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/resp_serializer.sv
// Shifts a loaded response (up to 7 bytes) out over a valid/ready byte
// interface, one byte per handshake with no bubbles between bytes.
module resp_serializer (
  input  logic        clk,
  input  logic        rstn,
  input  logic        load,
  input  logic [55:0] load_bytes,
  input  logic [2:0]  load_len,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        last_done
);

  logic [55:0] bytes_q;
  logic [2:0]  len_q;
  logic [2:0]  idx_q;
  logic        valid_q;
  logic        is_last;

  assign is_last   = (idx_q == len_q - 3'd1);
  assign tx_valid  = valid_q;
  assign tx_data   = bytes_q[{idx_q, 3'b000} +: 8];
  assign last_done = valid_q && tx_ready && is_last;

  // Data only moves on load or handshake, so tx_data holds during a stall.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bytes_q <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
    end else if (load) begin
      bytes_q <= load_bytes;
      len_q   <= load_len;
      idx_q   <= '0;
      valid_q <= 1'b1;
    end else if (valid_q && tx_ready) begin
      if (is_last) begin
        idx_q   <= '0;
        valid_q <= 1'b0;
      end else begin
        idx_q <= idx_q + 3'd1;
      end
    end
  end

endmodule

// File: rtl/cmd_exec_ctrl.sv
// Command execution sequencer: runs one register-bus transaction per decoded
// command (bounded by a timeout) and serialises the response to UART TX.
module cmd_exec_ctrl
  import comm_defs_pkg::*;
#(
  parameter int TIMEOUT_CYC = 1024,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             sm_start,
  input  logic [31:0]      addr_in,
  input  logic [31:0]      wrdata_in,
  input  logic             we_in,
  input  logic             decode_err,
  input  logic [15:0]      err_code,
  output logic             bus_req,
  output logic             bus_we,
  output logic [31:0]      bus_addr,
  output logic [31:0]      bus_wdata,
  input  logic             bus_gnt,
  input  logic             bus_rvalid,
  input  logic [31:0]      bus_rdata,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic             busy,
  output logic [CNT_W-1:0] drop_cnt
);

  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);

  exec_state_e state, next_state;
  resp_kind_e  kind_q, kind_d;

  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic          we_q;
  logic [15:0]   code_q;
  logic [31:0]   rdata_q;
  logic [TW-1:0] timer_q;
  logic          rd_capture;
  logic          timed_out;
  logic          ser_load;
  logic          ser_done;
  resp_bytes_t   resp_bytes;

  assign timed_out  = (timer_q == T_LAST);
  assign resp_bytes = build_resp(kind_q, code_q, rdata_q);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Completion is tested before the timer so a same-cycle finish wins.
  always_comb begin
    next_state = state;
    kind_d     = kind_q;
    rd_capture = 1'b0;
    case (state)
      IDLE: begin
        if (sm_start) begin
          if (decode_err) begin
            next_state = RESP;
            kind_d     = RSP_DERR;
          end else begin
            next_state = BUS_REQ;
          end
        end
      end
      BUS_REQ: begin
        if (bus_gnt && we_q) begin
          next_state = RESP;
          kind_d     = RSP_WOK;
        end else if (bus_gnt && bus_rvalid) begin
          next_state = RESP;
          kind_d     = RSP_ROK;
          rd_capture = 1'b1;
        end else if (timed_out) begin
          next_state = RESP;
          kind_d     = RSP_TOUT;
        end else if (bus_gnt) begin
          next_state = BUS_RD;
        end
      end
      BUS_RD: begin
        if (bus_rvalid) begin
          next_state = RESP;
          kind_d     = RSP_ROK;
          rd_capture = 1'b1;
        end else if (timed_out) begin
          next_state = RESP;
          kind_d     = RSP_TOUT;
        end
      end
      RESP: begin
        if (ser_done) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // The first RESP cycle loads the serialiser; tx_valid follows a cycle later.
  always_comb begin
    bus_req   = (state == BUS_REQ);
    bus_we    = bus_req ? we_q : 1'b0;
    bus_addr  = bus_req ? addr_q : 32'd0;
    bus_wdata = bus_req ? wdata_q : 32'd0;
    busy      = (state != IDLE);
    ser_load  = (state == RESP) && !tx_valid;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      code_q  <= '0;
      rdata_q <= '0;
      kind_q  <= RSP_DERR;
      timer_q <= '0;
    end else begin
      kind_q <= kind_d;
      if (state == IDLE && sm_start) begin
        addr_q  <= addr_in;
        wdata_q <= wrdata_in;
        we_q    <= we_in;
        code_q  <= err_code;
        timer_q <= '0;
      end else if (state == BUS_REQ || state == BUS_RD) begin
        timer_q <= timer_q + 1'b1;
      end
      if (rd_capture) begin
        rdata_q <= bus_rdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      drop_cnt <= '0;
    end else if (sm_start && state != IDLE && drop_cnt != '1) begin
      drop_cnt <= drop_cnt + 1'b1;
    end
  end

  resp_serializer u_ser (
    .clk        (clk),
    .rstn       (rstn),
    .load       (ser_load),
    .load_bytes (resp_bytes),
    .load_len   (resp_len(kind_q)),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .last_done  (ser_done)
  );

endmodule

// File: tb/tb_cmd_exec_ctrl.sv
// Randomised scoreboard bench for cmd_exec_ctrl: expected response bytes are
// queued per command and a monitor pops them on every TX handshake.
module tb_cmd_exec_ctrl;

  localparam int TO = 16;
  localparam int CW = 2;

  logic          clk;
  logic          rstn;
  logic          sm_start;
  logic [31:0]   addr_in;
  logic [31:0]   wrdata_in;
  logic          we_in;
  logic          decode_err;
  logic [15:0]   err_code;
  logic          bus_req;
  logic          bus_we;
  logic [31:0]   bus_addr;
  logic [31:0]   bus_wdata;
  logic          bus_gnt;
  logic          bus_rvalid;
  logic [31:0]   bus_rdata;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic          busy;
  logic [CW-1:0] drop_cnt;

  int checks = 0;
  int errors = 0;
  int ready_mode = 0;
  int drops = 0;
  logic [7:0] exp_q[$];

  cmd_exec_ctrl #(.TIMEOUT_CYC(TO), .CNT_W(CW)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .sm_start   (sm_start),
    .addr_in    (addr_in),
    .wrdata_in  (wrdata_in),
    .we_in      (we_in),
    .decode_err (decode_err),
    .err_code   (err_code),
    .bus_req    (bus_req),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_gnt    (bus_gnt),
    .bus_rvalid (bus_rvalid),
    .bus_rdata  (bus_rdata),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .busy       (busy),
    .drop_cnt   (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_drops();
    return (drops > (1 << CW) - 1) ? (1 << CW) - 1 : drops;
  endfunction

  // Reference response: what the UART should see for a command outcome.
  task automatic pushExpected(input logic derr, input logic we, input logic [15:0] code,
                              input logic [31:0] rdata, input bit done);
    if (derr) begin
      exp_q.push_back(8'h45);
      exp_q.push_back(code[15:8]);
      exp_q.push_back(code[7:0]);
    end else if (!done) begin
      exp_q.push_back(8'h45);
      exp_q.push_back(8'h39);
      exp_q.push_back(8'h39);
    end else if (we) begin
      exp_q.push_back(8'h4B);
    end else begin
      exp_q.push_back(8'h4B);
      exp_q.push_back(rdata[31:24]);
      exp_q.push_back(rdata[23:16]);
      exp_q.push_back(rdata[15:8]);
      exp_q.push_back(rdata[7:0]);
    end
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  task automatic drainResponse(input logic derr);
    for (int i = 0; i < 400 && busy; i++) begin
      if (derr) checkOutput("derr_no_bus_req", bus_req, 1'b0);
      step();
    end
    checkOutput("idle_after_resp", busy, 1'b0);
    checkOutput("resp_bytes_left", exp_q.size(), 0);
    checkOutput("tx_valid_idle", tx_valid, 1'b0);
  endtask

  // Bus responder grants gdelay cycles after bus_req rises; a read returns
  // data rdelay cycles after the grant. Completion must land by cycle TO-1.
  task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic derr, input logic [15:0] code,
                               input int gdelay, input int rdelay,
                               input logic [31:0] rdata, input bit late_rv);
    bit done;
    done = derr ? 1'b1 : (we ? (gdelay <= TO - 1) : (gdelay + rdelay <= TO - 1));
    pushExpected(derr, we, code, rdata, done);
    addr_in    = addr;
    wrdata_in  = wdata;
    we_in      = we;
    decode_err = derr;
    err_code   = code;
    sm_start   = 1'b1;
    step();
    sm_start   = 1'b0;
    addr_in    = $urandom;
    wrdata_in  = $urandom;
    we_in      = ~we;
    err_code   = 16'h0000;
    decode_err = 1'b0;
    if (!derr) begin
      for (int t = 0; t < TO; t++) begin
        checkOutput("bus_req", bus_req, (t <= gdelay));
        if (t <= gdelay) begin
          checkOutput("bus_we", bus_we, we);
          checkOutput("bus_addr", bus_addr, addr);
          checkOutput("bus_wdata", bus_wdata, wdata);
        end
        bus_gnt    = (t == gdelay);
        bus_rvalid = !we && (t == gdelay + rdelay);
        bus_rdata  = bus_rvalid ? rdata : $urandom;
        step();
        bus_gnt    = 1'b0;
        bus_rvalid = 1'b0;
        if ((we && t == gdelay) || (!we && t == gdelay + rdelay)) break;
      end
      checkOutput("bus_req_released", bus_req, 1'b0);
      if (late_rv) begin
        bus_rvalid = 1'b1;
        bus_rdata  = $urandom;
        step();
        bus_rvalid = 1'b0;
      end
    end
    drainResponse(derr);
  endtask

  initial begin
    int phase;
    phase = 0;
    tx_ready = 1'b0;
    forever begin
      step();
      case (ready_mode)
        0: tx_ready = 1'b1;
        1: tx_ready = 1'($urandom_range(0, 1));
        2: begin
          tx_ready = (phase == 0 || phase == 3);
          phase = (phase + 1) % 4;
        end
        default: tx_ready = 1'b0;
      endcase
    end
  end

  // Scoreboard monitor, also enforcing hold-while-stalled on the TX port.
  initial begin
    logic stalled;
    logic [7:0] held;
    stalled = 1'b0;
    held = 8'h00;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        stalled = 1'b0;
      end else begin
        if (stalled) begin
          checkOutput("tx_valid_held", tx_valid, 1'b1);
          checkOutput("tx_data_stable", tx_data, held);
        end
        if (tx_valid && tx_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_byte: got 0x%0h, expected no byte", tx_data);
          end else begin
            checkOutput("tx_byte", tx_data, exp_q.pop_front());
          end
        end
        stalled = tx_valid && !tx_ready;
        held = tx_data;
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected simulation end");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rstn = 1'b0;
    sm_start = 1'b0;
    addr_in = '0;
    wrdata_in = '0;
    we_in = 1'b0;
    decode_err = 1'b0;
    err_code = '0;
    bus_gnt = 1'b0;
    bus_rvalid = 1'b0;
    bus_rdata = '0;
    step();
    step();
    checkOutput("rst_bus_req", bus_req, 1'b0);
    checkOutput("rst_bus_we", bus_we, 1'b0);
    checkOutput("rst_bus_addr", bus_addr, 32'h0);
    checkOutput("rst_bus_wdata", bus_wdata, 32'h0);
    checkOutput("rst_tx_valid", tx_valid, 1'b0);
    checkOutput("rst_tx_data", tx_data, 8'h00);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_drop_cnt", drop_cnt, 0);
    rstn = 1'b1;
    step();

    $display("[TB] directed write, read, decode error, timeouts");
    ready_mode = 0;
    applyStimulus(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 16'h0, 3, 0, 32'h0, 1'b0);
    ready_mode = 2;
    applyStimulus(1'b0, 32'h0000_0020, 32'h0, 1'b0, 16'h0, 2, 2, 32'h1234_5678, 1'b0);
    ready_mode = 0;
    applyStimulus(1'b0, 32'h0000_0030, 32'h0, 1'b1, 16'h3232, 0, 0, 32'h0, 1'b0);
    applyStimulus(1'b1, 32'h0000_0040, 32'h5555_AAAA, 1'b0, 16'h0, 1000, 0, 32'h0, 1'b1);
    applyStimulus(1'b0, 32'h0000_0044, 32'h0, 1'b0, 16'h0, 4, 40, 32'hCAFE_F00D, 1'b1);
    applyStimulus(1'b1, 32'h0000_0048, 32'h0BAD_F00D, 1'b0, 16'h0, TO - 1, 0, 32'h0, 1'b0);
    applyStimulus(1'b0, 32'h0000_004C, 32'h0, 1'b0, 16'h0, 10, TO - 11, 32'hA5A5_5A5A, 1'b0);

    $display("[TB] dropped commands during a stalled response");
    ready_mode = 3;
    pushExpected(1'b1, 1'b0, 16'h3431, 32'h0, 1'b1);
    decode_err = 1'b1;
    err_code = 16'h3431;
    sm_start = 1'b1;
    step();
    sm_start = 1'b0;
    decode_err = 1'b0;
    for (int i = 0; i < 10 && !tx_valid; i++) step();
    checkOutput("tx_valid_rise", tx_valid, 1'b1);
    for (int i = 0; i < 5; i++) begin
      addr_in = $urandom;
      sm_start = 1'b1;
      step();
      sm_start = 1'b0;
      drops++;
      step();
      if (i == 2) checkOutput("drop_cnt_three", drop_cnt, exp_drops());
    end
    checkOutput("drop_cnt_saturated", drop_cnt, exp_drops());
    ready_mode = 0;
    drainResponse(1'b1);

    $display("[TB] reset while waiting for read data");
    sm_start = 1'b1;
    we_in = 1'b0;
    addr_in = 32'h0000_0050;
    step();
    sm_start = 1'b0;
    bus_gnt = 1'b1;
    step();
    bus_gnt = 1'b0;
    step();
    checkOutput("bus_rd_no_req", bus_req, 1'b0);
    rstn = 1'b0;
    #1;
    checkOutput("midrst_bus_req", bus_req, 1'b0);
    checkOutput("midrst_tx_valid", tx_valid, 1'b0);
    checkOutput("midrst_busy", busy, 1'b0);
    checkOutput("midrst_drop_cnt", drop_cnt, 0);
    drops = 0;
    exp_q.delete();
    step();
    rstn = 1'b1;
    step();
    applyStimulus(1'b0, 32'h0000_0054, 32'h0, 1'b0, 16'h0, 1, 1, 32'h8765_4321, 1'b0);

    $display("[TB] randomised commands");
    ready_mode = 1;
    for (int n = 0; n < 40; n++) begin
      applyStimulus(1'($urandom_range(0, 1)), $urandom, $urandom,
                    ($urandom_range(0, 5) == 0), 16'($urandom),
                    $urandom_range(0, 18), $urandom_range(0, 5),
                    $urandom, 1'($urandom_range(0, 1)));
    end
    checkOutput("final_drop_cnt", drop_cnt, exp_drops());

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
